issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue-stage hazard scheduler between the dispatcher and the in-order writeback/commit stage.
- Tracks destination registers of instructions dispatched but not yet committed.
- Stalls dispatch of any instruction whose source register has a pending write (RAW). There is no bypass network.
- Bounds total in-flight instructions to the EX FIFO depth, and clears all tracking on a PC redirect (branch taken, trap, xRET).

Parameters:
- NREGS, 32, architectural integer registers tracked; x0 is never tracked.
- MAX_INFLIGHT, 4, maximum dispatched-but-uncommitted instructions; must match the EX FIFO depth.
- CNT_W, $clog2(MAX_INFLIGHT+1), width of the per-register and total counters (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- disp_valid  in  1  dispatcher presents an instruction.
- disp_ready  out  1  scoreboard accepts; dispatch fires when disp_valid && disp_ready.
- disp_rs1  in  5  source register 1 index.
- disp_rs1_use  in  1  instruction reads rs1.
- disp_rs2  in  5  source register 2 index.
- disp_rs2_use  in  1  instruction reads rs2.
- disp_rd  in  5  destination register index (0 = no write).
- commit_valid  in  1  one instruction retires this cycle; this is the committer's wbrf tvalid.
- commit_rd  in  5  decoded rd of the retiring instruction, taken before trap suppression.
- flush  in  1  PC redirect accepted this cycle; this is the committer's wbpcg tvalid && tready.
- busy  out  NREGS  per-register pending flag, for debug and performance counters.
- inflight  out  CNT_W  current in-flight instruction count.

Behaviour:
- Reset (async assert): all per-register counters cnt[r]=0, inflight=0, busy=0, disp_ready=0 while rst is high.
- State: cnt[1..NREGS-1] of CNT_W bits, plus inflight. cnt[0] is constant 0.
- hazard = (disp_rs1_use && disp_rs1!=0 && cnt[disp_rs1]!=0) || (disp_rs2_use && disp_rs2!=0 && cnt[disp_rs2]!=0).
- disp_ready = !rst && !flush && !hazard && inflight<MAX_INFLIGHT.
  - Computed from registered state only.
  - A commit in cycle N releases the hazard in cycle N+1 (one-cycle commit-to-issue latency).
  - There is no combinational path from commit_valid/commit_rd to disp_ready.
- disp_ready must not depend on disp_valid (AXIS rule).
  - It does depend on disp_rs*/disp_rd payload.
  - The dispatcher holds the payload stable while valid.
- Dispatch fire: inflight+1; if disp_rd!=0 then cnt[disp_rd]+1.
- Commit: inflight-1; if commit_rd!=0 then cnt[commit_rd]-1.
- Dispatch and commit in the same cycle:
  - inflight is unchanged.
  - If disp_rd==commit_rd!=0, that counter is unchanged.
  - Otherwise each counter updates independently.
- WAW (second write to a pending rd) is permitted. The counter increments, which is why counters are used instead of single bits.
- Flush:
  - Next state: all cnt=0, inflight=0.
  - Flush overrides any same-cycle commit.
  - Dispatch cannot fire, since disp_ready=0.
  - Rationale: commit is in-order, so every instruction still in flight at a redirect is younger and is discarded by the EX FIFO flush.
- Flush occurs in the same cycle as the redirecting instruction's commit_valid; that commit is absorbed by the clear.
- Trapping instruction: the committer forces rd=0 on the RF write, but commit_rd carries the original rd. The trap also raises flush, so all counters clear regardless.
- Underflow (commit with inflight==0, or cnt[commit_rd]==0) is a protocol error.
  - Counters saturate at 0.
  - A simulation assertion fires.
- Overflow is impossible because inflight<=MAX_INFLIGHT gates dispatch; an assertion checks cnt[r]<=inflight.
- busy[r] = (cnt[r]!=0); busy[0]=0.

Decomposition:
- In offnariscv_pkg: add type sb_cnt_t (logic [CNT_W-1:0] with CNT_W from EXFIFO_DEPTH), and add constant EXFIFO_DEPTH shared with the EX FIFO instance so MAX_INFLIGHT defaults to it.
- Use reg_idx_t (5-bit) from riscv_pkg for register indices.
- One sub-module: sb_reg_counter, an up/down/clear counter with saturation at 0, instantiated NREGS-1 times via generate.

Test Plan:
- Reset: hold rst=1 mid-stream with cnt[5]=2 -> busy=0, inflight=0, disp_ready=0 asynchronously; after release, disp_ready=1 for rs1=5.
- RAW stall: dispatch rd=5; next cycle present rs1=5 -> disp_ready=0. Commit rd=5 in cycle N -> disp_ready=1 in N+1, not in N.
- WAW plus same-cycle update:
  - Dispatch rd=7 twice -> cnt[7]=2.
  - Cycle with dispatch rd=7 and commit rd=7 -> cnt[7]=2, inflight unchanged.
  - Two further commits of rd=7 -> busy[7]=0.
- Capacity: MAX_INFLIGHT=4, dispatch 4 instructions with rd=0 -> inflight=4, disp_ready=0 with no hazard. One commit -> disp_ready=1 next cycle.
- Flush: 3 in flight (rd=1,2,3); flush coincident with commit rd=1 and disp_valid -> next cycle inflight=0, busy=0, no dispatch accepted in the flush cycle.
- x0 and trap: dispatch rd=0 and rs1=0 -> no hazard, cnt unchanged. Trap commit with commit_rd=9 plus flush -> cnt[9]=0, no underflow assertion.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue-stage hazard scoreboard.
//   EXFIFO_DEPTH : depth of the EX FIFO; bounds the dispatched-but-uncommitted count
//   SB_CNT_W     : width of a scoreboard counter able to hold 0..EXFIFO_DEPTH
//   sb_cnt_t     : scoreboard counter type
//   reg_idx_t    : 5-bit architectural integer register index
package issue_scoreboard_pkg;

   localparam int EXFIFO_DEPTH = 4;
   localparam int SB_CNT_W     = $clog2(EXFIFO_DEPTH + 1);

   typedef logic [SB_CNT_W-1:0] sb_cnt_t;
   typedef logic [4:0]          reg_idx_t;

   // x0 is hardwired to zero, so it never carries a pending write.
   function automatic logic idx_is_reg(input reg_idx_t idx);
      return idx != 5'd0;
   endfunction

endpackage

// File: rtl/issue_scoreboard_chk.sv
// Protocol checker for the issue scoreboard (simulation assertions only).
//   clk, rst     : clock, asynchronous active-high reset
//   commit_valid : an instruction retires this cycle
//   commit_rd    : its destination register
//   flush        : PC redirect this cycle
//   inflight     : in-flight instruction count
//   cnt          : per-register pending-write counters
module issue_scoreboard_chk
   import issue_scoreboard_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int CNT_W = SB_CNT_W
) (
   input logic             clk,
   input logic             rst,
   input logic             commit_valid,
   input reg_idx_t         commit_rd,
   input logic             flush,
   input logic [CNT_W-1:0] inflight,
   input logic [CNT_W-1:0] cnt [NREGS]
);

   // A commit absorbed by a flush is never an underflow (trap / redirect case).
   a_inflight_underflow: assert property (@(posedge clk) disable iff (rst)
      (commit_valid && !flush) |-> (inflight != '0))
      else $error("issue_scoreboard: commit with no instruction in flight");

   a_cnt_underflow: assert property (@(posedge clk) disable iff (rst)
      (commit_valid && !flush && idx_is_reg(commit_rd)) |-> (cnt[commit_rd] != '0))
      else $error("issue_scoreboard: commit to register with no pending write");

   for (genvar r = 1; r < NREGS; r++) begin : g_bound
      a_cnt_le_inflight: assert property (@(posedge clk) disable iff (rst)
         cnt[r] <= inflight)
         else $error("issue_scoreboard: register counter exceeds in-flight count");
   end

endmodule

// File: rtl/issue_scoreboard_sb_reg_counter.sv
// Up/down/clear counter that saturates at zero.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one
//   dec      : count down by one (holds at zero)
//   clr      : clear to zero, dominates inc/dec
//   cnt      : registered count
// Simultaneous inc and dec cancel. Overflow is prevented by the caller.
module sb_reg_counter
   import issue_scoreboard_pkg::*;
#(
   parameter int W = SB_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_nxt_s;

   // Next count: clear first, then net up/down with saturation at zero.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr) begin
         cnt_nxt_s = '0;
      end else if (inc && !dec) begin
         cnt_nxt_s = cnt_r + W'(1);
      end else if (dec && !inc) begin
         if (cnt_r != '0) begin
            cnt_nxt_s = cnt_r - W'(1);
         end else begin
            cnt_nxt_s = '0;
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage RAW hazard scoreboard between dispatcher and in-order commit.
//   clk, rst                 : clock, asynchronous active-high reset
//   disp_valid / disp_ready  : dispatch handshake (ready independent of valid)
//   disp_rs1/_use, rs2/_use  : source registers and whether they are read
//   disp_rd                  : destination register (0 = no write)
//   commit_valid / commit_rd : one retirement per cycle, rd before trap masking
//   flush                    : PC redirect; discards all in-flight tracking
//   busy                     : per-register pending-write flags
//   inflight                 : dispatched-but-uncommitted count
// No bypass network: a source with any pending write stalls dispatch. Ready is
// derived from registered counters only, so a commit releases a hazard one
// cycle later.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter  int NREGS        = 32,
   parameter  int MAX_INFLIGHT = EXFIFO_DEPTH,
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  reg_idx_t         disp_rs1,
   input  logic             disp_rs1_use,
   input  reg_idx_t         disp_rs2,
   input  logic             disp_rs2_use,
   input  reg_idx_t         disp_rd,
   input  logic             commit_valid,
   input  reg_idx_t         commit_rd,
   input  logic             flush,
   output logic [NREGS-1:0] busy,
   output logic [CNT_W-1:0] inflight
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] cnt_s [NREGS];
   logic [CNT_W-1:0] inflight_s;
   logic [NREGS-1:0] busy_s;
   logic             hazard_s;
   logic             ready_s;
   logic             fire_s;

   assign cnt_s[0] = '0;

   assign hazard_s = (disp_rs1_use && idx_is_reg(disp_rs1) && (cnt_s[disp_rs1] != '0)) ||
                     (disp_rs2_use && idx_is_reg(disp_rs2) && (cnt_s[disp_rs2] != '0));

   assign ready_s = !rst && !flush && !hazard_s && (inflight_s < MAX_CNT);
   assign fire_s  = disp_valid && ready_s;

   // Total in-flight count; a same-cycle dispatch and commit cancel.
   sb_reg_counter #(.W(CNT_W)) u_inflight (
      .clk (clk),
      .rst (rst),
      .inc (fire_s),
      .dec (commit_valid),
      .clr (flush),
      .cnt (inflight_s)
   );

   // One pending-write counter per register; counters allow WAW to stack.
   for (genvar r = 1; r < NREGS; r++) begin : g_reg
      sb_reg_counter #(.W(CNT_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (fire_s && (disp_rd == reg_idx_t'(r))),
         .dec (commit_valid && !flush && (commit_rd == reg_idx_t'(r))),
         .clr (flush),
         .cnt (cnt_s[r])
      );
   end

   // Pending flags; bit 0 stays clear for x0.
   always_comb begin
      busy_s = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy_s[r] = (cnt_s[r] != '0);
      end
   end

   assign disp_ready = ready_s;
   assign busy       = busy_s;
   assign inflight   = inflight_s;

   issue_scoreboard_chk #(.NREGS(NREGS), .CNT_W(CNT_W)) u_chk (
      .clk          (clk),
      .rst          (rst),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .flush        (flush),
      .inflight     (inflight_s),
      .cnt          (cnt_s)
   );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a table of per-cycle vectors with
// hand-derived expectations (ready checked in-cycle, next-state results queued
// and checked after the clock edge), plus a hand-written async reset sequence.
module tb_issue_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_valid;
   logic        disp_ready;
   logic [4:0]  disp_rs1;
   logic        disp_rs1_use;
   logic [4:0]  disp_rs2;
   logic        disp_rs2_use;
   logic [4:0]  disp_rd;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic        flush;
   logic [31:0] busy;
   logic [2:0]  inflight;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        cv;
      logic [4:0]  crd;
      logic        fl;
      logic        exp_ready;
      int          exp_inf;
      logic [31:0] exp_busy;
   } vec_t;

   typedef struct {
      int          idx;
      int          inf;
      logic [31:0] bsy;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   issue_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .disp_valid   (disp_valid),
      .disp_ready   (disp_ready),
      .disp_rs1     (disp_rs1),
      .disp_rs1_use (disp_rs1_use),
      .disp_rs2     (disp_rs2),
      .disp_rs2_use (disp_rs2_use),
      .disp_rd      (disp_rd),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .flush        (flush),
      .busy         (busy),
      .inflight     (inflight)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic cv, input logic [4:0] crd, input logic fl,
                      input logic er, input int einf, input logic [31:0] eb);
      vec_t t;
      t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
      t.cv = cv; t.crd = crd; t.fl = fl;
      t.exp_ready = er; t.exp_inf = einf; t.exp_busy = eb;
      vecs.push_back(t);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk($sformatf("inflight[%0d]", e.idx), 32'(inflight), 32'(e.inf));
         chk($sformatf("busy[%0d]", e.idx), busy, e.bsy);
      end
   endtask

   task automatic idle_inputs();
      disp_valid = 1'b0; disp_rs1 = 5'd0; disp_rs1_use = 1'b0;
      disp_rs2 = 5'd0; disp_rs2_use = 1'b0; disp_rd = 5'd0;
      commit_valid = 1'b0; commit_rd = 5'd0; flush = 1'b0;
   endtask

   initial begin
      exp_t e;
      //  v     rs1   u1    rs2   u2    rd     cv    crd    fl    rdy  inf busy
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 0, 32'h0);
      // RAW stall and one-cycle commit-to-issue latency
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h20);
      add(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6,  1'b0, 5'd0,  1'b0, 1'b0, 1, 32'h20);
      add(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6,  1'b1, 5'd5,  1'b0, 1'b0, 0, 32'h0);
      add(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h40);
      add(1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 5'd7,  1'b1, 5'd6,  1'b0, 1'b0, 0, 32'h0);
      // x0 source, WAW and same-cycle dispatch+commit on the same rd
      add(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h80);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 2, 32'h80);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7,  1'b1, 5'd7,  1'b0, 1'b1, 2, 32'h80);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b0, 1'b1, 1, 32'h80);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b0, 1'b1, 0, 32'h0);
      // capacity limit with rd=0
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 2, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 3, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 4, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 4, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 3, 32'h0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 4, 32'h0);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 3, 32'h0);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b1, 2, 32'h0);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b1, 1, 32'h0);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b1, 0, 32'h0);
      // flush with coincident commit and dispatch attempt
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h2);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2,  1'b0, 5'd0,  1'b0, 1'b1, 2, 32'h6);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,  1'b0, 5'd0,  1'b0, 1'b1, 3, 32'hE);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4,  1'b1, 5'd1,  1'b1, 1'b0, 0, 32'h0);
      add(1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 0, 32'h0);
      // trap: commit with original rd plus flush
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h200);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b1, 1'b0, 0, 32'h0);
      add(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1, 32'h0);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b1, 0, 32'h0);

      // initial reset
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("reset_ready", 32'(disp_ready), 32'h0);
      chk("reset_inflight", 32'(inflight), 32'h0);
      chk("reset_busy", busy, 32'h0);
      rst = 1'b0;

      // table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drain();
         disp_valid   = vecs[i].v;
         disp_rs1     = vecs[i].rs1;
         disp_rs1_use = vecs[i].u1;
         disp_rs2     = vecs[i].rs2;
         disp_rs2_use = vecs[i].u2;
         disp_rd      = vecs[i].rd;
         commit_valid = vecs[i].cv;
         commit_rd    = vecs[i].crd;
         flush        = vecs[i].fl;
         #1;
         chk($sformatf("ready[%0d]", i), 32'(disp_ready), 32'(vecs[i].exp_ready));
         e.idx = i; e.inf = vecs[i].exp_inf; e.bsy = vecs[i].exp_busy;
         exp_q.push_back(e);
      end
      @(negedge clk);
      drain();

      // mid-stream async reset with cnt[5]=2
      idle_inputs();
      disp_valid = 1'b1;
      disp_rd    = 5'd5;
      repeat (2) @(negedge clk);
      idle_inputs();
      #1;
      chk("pre_rst_inflight", 32'(inflight), 32'h2);
      chk("pre_rst_busy", busy, 32'h20);
      rst = 1'b1;
      #1;
      chk("async_rst_ready", 32'(disp_ready), 32'h0);
      chk("async_rst_inflight", 32'(inflight), 32'h0);
      chk("async_rst_busy", busy, 32'h0);
      @(negedge clk);
      rst          = 1'b0;
      disp_valid   = 1'b1;
      disp_rs1     = 5'd5;
      disp_rs1_use = 1'b1;
      #1;
      chk("post_rst_ready", 32'(disp_ready), 32'h1);
      @(negedge clk);
      idle_inputs();
      chk("post_rst_inflight", 32'(inflight), 32'h1);
      chk("post_rst_busy", busy, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
